mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller that shares the single 8-bit RAM port between instruction fetch (IF) and the load/store traffic leaving the execute stage (MEM). Each access is split into 1, 2 or 4 byte cycles on the RAM port. Requesters are arbitrated, and load data is sign- or zero-extended. An in-flight instruction fetch is aborted when EX redirects the PC.

## Interface

Parameters: none. Op encodings and widths come from `config.v` (`OpLen`, `LB`…`SW`).

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  global ready; 0 pauses the controller
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse; if_inst valid in that cycle
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  load/store request, held until mem_done
- mem_op  in  `OpLen`  one of LB/LH/LW/LBU/LHU/SB/SH/SW
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data; low bytes used
- mem_done  out  1  one-cycle pulse; mem_rdata valid in that cycle for loads
- mem_rdata  out  32  extended load result
- jump_flush  in  1  EX jump_or_not; aborts an IF access
- ram_din  in  8  RAM read data; valid one cycle after ram_a
- ram_dout  out  8  RAM write data
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write ram_dout to ram_a at this edge
- busy  out  1  state != IDLE

## Operation

- States: IDLE, RD, WR. Byte counter cnt is 3 bits. N is the access size: 1 for B/BU, 2 for H/HU, 4 for W and for IF.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0. All outputs are 0: if_done, mem_done, if_inst, mem_rdata, ram_a, ram_dout, ram_wr, busy.
- IDLE arbitration:
  - mem_req has priority over if_req.
  - A requester whose done is high in the current cycle is masked.
  - if_req is ignored while jump_flush=1.
  - On acceptance, latch base address, op, wdata and owner. Go to RD (loads, IF) or WR (stores) with cnt=0.
- RD:
  - ram_a = base+cnt while cnt<N; otherwise it holds base+N-1.
  - At each edge with cnt≥1, ram_din is stored into byte cnt-1.
  - At the edge with cnt==N: the result is registered (including the current ram_din), the owner's done is set, and state returns to IDLE.
- WR:
  - ram_wr=1, ram_a=base+cnt, ram_dout=wdata[8·cnt+7:8·cnt].
  - At the edge with cnt==N-1: mem_done is set and state returns to IDLE.
- Extension:
  - LB and LH sign-extend from bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW and IF pass the word unmodified, with byte 0 as the LSB.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFF+1 → 0x00000000.
- Flush:
  - jump_flush=1 while the owner is IF in RD: next state is IDLE and if_done is not raised. This holds even at cnt==N, where flush wins.
  - MEM transactions are never affected by flush.
  - An if_done pulse already on the outputs is not retracted.
- rdy=0:
  - ram_wr is forced to 0. State and latched request are held.
  - In RD, cnt is cleared to 0 so the access restarts cleanly on resume.
  - In WR, cnt is held and the write resumes at the same byte.
  - done pulses still clear at the next edge.
- ram_a, ram_dout and ram_wr are 0 in IDLE.

## Timing

- Cycle 0: the request is sampled in IDLE.
- Loads and fetches: done is high in cycle N+2.
  - LB: cycle 3.
  - LW and IF: cycle 6.
- Stores: done is high in cycle N+1.
  - SB: cycle 2.
  - SW: cycle 5.
- Done is high for exactly one cycle. Data outputs hold their value until the next completion.
- A back-to-back request from the other requester is accepted in the done cycle, with no bubble.
- A requester must deassert req in its done cycle.

## Test plan

- Reset / IF fetch: release reset. RAM[0x1000..0x1003]=13 05 00 00; if_req at 0x1000 → ram_a 0x1000..0x1003 in cycles 1–4; if_inst=0x00000513 with if_done=1 in cycle 6 only.
- Arbitration and sign extension: if_req and mem_req(LB @0x20, RAM=0x80) in the same cycle → mem_done with mem_rdata=0xFFFFFF80 in cycle 3; IF accepted in cycle 3, if_done in cycle 9. With LBU on the same byte → mem_rdata=0x00000080.
- Store: SH, mem_addr=0x3001, wdata=0x1234ABCD → ram_wr=1 with (0x3001,0xCD) in cycle 1 and (0x3002,0xAB) in cycle 2; mem_done in cycle 3; ram_wr=0 afterwards.
- Flush: jump_flush=1 during IF RD at cnt=2 → no if_done, busy=0 in the next cycle. A new if_req @0x2000 is then served correctly.
- rdy stall: LW @0x40 (RAM=EF BE AD DE), rdy=0 for 2 cycles at cnt=2 → no ram_wr, read restarts from 0x40; mem_rdata=0xDEADBEEF, done delayed accordingly. SW with rdy=0 mid-write → no lost or duplicated bytes.
- Async reset mid-write: assert rst=0 during SW cnt=1 → ram_wr=0 immediately, all outputs 0; no done after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller sharing one 8-bit RAM port between
// instruction fetch and load/store traffic, with load extension and
// fetch abort on PC redirect.

package mem_ctrl_pkg;
  localparam int OpLen = 4;
  // Op layout: bit 3 = store, bit 2 = unsigned load, bits 1:0 = log2(bytes).
  localparam logic [OpLen-1:0] LB  = 4'b0000;
  localparam logic [OpLen-1:0] LH  = 4'b0001;
  localparam logic [OpLen-1:0] LW  = 4'b0010;
  localparam logic [OpLen-1:0] LBU = 4'b0100;
  localparam logic [OpLen-1:0] LHU = 4'b0101;
  localparam logic [OpLen-1:0] SB  = 4'b1000;
  localparam logic [OpLen-1:0] SH  = 4'b1001;
  localparam logic [OpLen-1:0] SW  = 4'b1010;
endpackage

module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_done,
  output logic [31:0]      if_inst,
  input  logic             mem_req,
  input  logic [OpLen-1:0] mem_op,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic             mem_done,
  output logic [31:0]      mem_rdata,
  input  logic             jump_flush,
  input  logic [7:0]       ram_din,
  output logic [7:0]       ram_dout,
  output logic [31:0]      ram_a,
  output logic             ram_wr,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;

  // Handshake: a requester holds req (with stable operands) until its done
  // pulse; done is high for exactly one cycle and req must drop in it.

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [31:0]      base_q, base_d;
  logic [OpLen-1:0] op_q, op_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             own_if_q, own_if_d;
  logic [31:0]      buf_q, buf_d;
  logic             if_done_q, if_done_d;
  logic             mem_done_q, mem_done_d;
  logic [31:0]      if_inst_q, if_inst_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;

  logic [2:0]       size_n;
  logic [31:0]      rd_word;
  logic [31:0]      rd_ext;
  logic [7:0]       wr_byte;

  // Access size in bytes: fetches are always a full word.
  always_comb begin
    size_n = 3'd4;
    if (!own_if_q) begin
      case (op_q[1:0])
        2'b00:   size_n = 3'd1;
        2'b01:   size_n = 3'd2;
        default: size_n = 3'd4;
      endcase
    end
  end

  // Read word with the byte arriving this cycle merged into slot cnt-1.
  always_comb begin
    rd_word = buf_q;
    case (cnt_q)
      3'd1:    rd_word[7:0]   = ram_din;
      3'd2:    rd_word[15:8]  = ram_din;
      3'd3:    rd_word[23:16] = ram_din;
      3'd4:    rd_word[31:24] = ram_din;
      default: ;
    endcase
  end

  // Sign/zero extension of the completed load.
  always_comb begin
    case (op_q)
      LB:      rd_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      LH:      rd_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      LBU:     rd_ext = {24'd0, rd_word[7:0]};
      LHU:     rd_ext = {16'd0, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // Store byte selected by the byte counter.
  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wr_byte = wdata_q[7:0];
      2'd1:    wr_byte = wdata_q[15:8];
      2'd2:    wr_byte = wdata_q[23:16];
      default: wr_byte = wdata_q[31:24];
    endcase
  end

  // Next-state logic: arbitration, byte sequencing, flush and stall handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    op_d        = op_q;
    wdata_d     = wdata_q;
    own_if_d    = own_if_q;
    buf_d       = buf_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (rdy) begin
          if (mem_req && !mem_done_q) begin
            base_d   = mem_addr;
            op_d     = mem_op;
            wdata_d  = mem_wdata;
            own_if_d = 1'b0;
            cnt_d    = 3'd0;
            state_d  = mem_op[3] ? WR : RD;
          end else if (if_req && !if_done_q && !jump_flush) begin
            base_d   = if_addr;
            own_if_d = 1'b1;
            cnt_d    = 3'd0;
            state_d  = RD;
          end
        end
      end
      RD: begin
        // A redirect kills the fetch even on its final edge.
        if (own_if_q && jump_flush) begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end else if (!rdy) begin
          // Restart the read sequence from byte 0 once resumed.
          cnt_d = 3'd0;
        end else begin
          if (cnt_q != 3'd0) buf_d = rd_word;
          if (cnt_q == size_n) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            if (own_if_q) begin
              if_done_d = 1'b1;
              if_inst_d = rd_word;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rd_ext;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      WR: begin
        // A stall holds cnt so the write resumes at the same byte.
        if (rdy) begin
          if (cnt_q == size_n - 3'd1) begin
            state_d    = IDLE;
            cnt_d      = 3'd0;
            mem_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      base_q      <= 32'd0;
      op_q        <= '0;
      wdata_q     <= 32'd0;
      own_if_q    <= 1'b0;
      buf_q       <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      op_q        <= op_d;
      wdata_q     <= wdata_d;
      own_if_q    <= own_if_d;
      buf_q       <= buf_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM port drive: quiet in IDLE, address holds on the last byte in RD.
  always_comb begin
    ram_a    = 32'd0;
    ram_dout = 8'd0;
    ram_wr   = 1'b0;
    case (state_q)
      RD: ram_a = base_q + {29'd0, (cnt_q < size_n) ? cnt_q : (size_n - 3'd1)};
      WR: begin
        ram_a    = base_q + {29'd0, cnt_q};
        ram_dout = wr_byte;
        ram_wr   = rdy;
      end
      default: ;
    endcase
  end

  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scenarios plus randomized traffic for mem_ctrl,
// checked against a byte-array memory model and an expected-result queue.

module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int MAX_CYC = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             rdy = 1'b1;
  logic             if_req = 1'b0;
  logic [31:0]      if_addr = 32'd0;
  logic             if_done;
  logic [31:0]      if_inst;
  logic             mem_req = 1'b0;
  logic [OpLen-1:0] mem_op = '0;
  logic [31:0]      mem_addr = 32'd0;
  logic [31:0]      mem_wdata = 32'd0;
  logic             mem_done;
  logic [31:0]      mem_rdata;
  logic             jump_flush = 1'b0;
  logic [7:0]       ram_din = 8'd0;
  logic [7:0]       ram_dout;
  logic [31:0]      ram_a;
  logic             ram_wr;
  logic             busy;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .jump_flush(jump_flush), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_a(ram_a), .ram_wr(ram_wr), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- RAM (environment) ----------------
  typedef struct packed { logic [15:0] a; logic [7:0] d; } poke_t;
  poke_t      poke_q[$];
  poke_t      pk;
  logic [7:0] ram_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    while (poke_q.size() > 0) begin
      pk = poke_q.pop_front();
      ram_mem[pk.a] <= pk.d;
    end
    if (ram_wr) ram_mem[ram_a[15:0]] <= ram_dout;
    ram_din <= ram_mem[ram_a[15:0]];
  end

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_t p;
    p.a = a;
    p.d = d;
    poke_q.push_back(p);
    ref_mem[a] = d;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_size(input bit is_if, input logic [3:0] op);
    if (is_if) return 4;
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      default:     return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input bit is_if, input logic [3:0] op,
                                             input logic [31:0] addr);
    longint u;
    int     n;
    bit     sgn;
    u   = 0;
    n   = model_size(is_if, op);
    sgn = !is_if && (op == LB || op == LH);
    for (int i = 0; i < n; i++)
      u += longint'(ref_mem[16'(addr + 32'(i))]) << (8 * i);
    if (sgn && u >= (longint'(1) << (8 * n - 1))) u -= (longint'(1) << (8 * n));
    return u[31:0];
  endfunction

  task automatic model_store(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata);
    for (int i = 0; i < model_size(1'b0, op); i++)
      ref_mem[16'(addr + 32'(i))] = wdata[8 * i +: 8];
  endtask

  // ---------------- driver ----------------
  logic [31:0] tr_a    [0:MAX_CYC-1];
  logic        tr_wr   [0:MAX_CYC-1];
  logic [7:0]  tr_do   [0:MAX_CYC-1];
  logic        tr_busy [0:MAX_CYC-1];
  int          tr_ifd_cnt;

  // Issues one request at cycle 0, returns the cycle its done was seen
  // (-1 if none within MAX_CYC). When rec is set it also owns rdy/jump_flush
  // and records the RAM port per cycle.
  task automatic run_req(input bit use_if, input logic [3:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int stall_at, input int stall_len, input int flush_at,
                         input bit rec, output int lat, output logic [31:0] rdata);
    lat   = -1;
    rdata = 32'd0;
    if (rec) tr_ifd_cnt = 0;
    @(posedge clk); #1;
    if (use_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      mem_req   = 1'b1;
      mem_op    = op;
      mem_addr  = addr;
      mem_wdata = wdata;
    end
    for (int k = 0; k < MAX_CYC; k++) begin
      if (rec) begin
        rdy        = !(k >= stall_at && k < stall_at + stall_len);
        jump_flush = (k == flush_at);
        if (use_if && flush_at >= 0 && k > flush_at) if_req = 1'b0;
      end
      @(negedge clk);
      if (rec) begin
        tr_a[k]    = ram_a;
        tr_wr[k]   = ram_wr;
        tr_do[k]   = ram_dout;
        tr_busy[k] = busy;
        if (if_done) tr_ifd_cnt++;
      end
      if (use_if ? if_done : mem_done) begin
        lat   = k;
        rdata = use_if ? if_inst : mem_rdata;
        if (use_if) if_req = 1'b0;
        else mem_req = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      if (use_if) if_req = 1'b0;
      else mem_req = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  int          lat, lat_i, errs, n_wr;
  logic [31:0] rd, rd_i, addr_r, wd_r;
  logic [3:0]  op_r;
  bit          is_if_r;
  logic [3:0]  ops [0:7];

  initial begin
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

    // Reset state
    repeat (3) @(negedge clk);
    check32("rst_ram_a", ram_a, 32'd0);
    check32("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check32("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_if_done", {31'd0, if_done}, 32'd0);
    check32("rst_mem_done", {31'd0, mem_done}, 32'd0);
    check32("rst_if_inst", if_inst, 32'd0);
    check32("rst_mem_rdata", mem_rdata, 32'd0);

    // Memory image
    poke(16'h1000, 8'h13); poke(16'h1001, 8'h05);
    poke(16'h1002, 8'h00); poke(16'h1003, 8'h00);
    poke(16'h0020, 8'h80);
    poke(16'h0040, 8'hEF); poke(16'h0041, 8'hBE);
    poke(16'h0042, 8'hAD); poke(16'h0043, 8'hDE);
    poke(16'hFFFF, 8'h34); poke(16'h0000, 8'h92);
    poke(16'h0060, 8'h00); poke(16'h0061, 8'h5A);
    for (int i = 0; i < 4; i++) poke(16'h2000 + 16'(i), 8'($urandom_range(0, 255)));
    for (int i = 0; i < 256; i++) poke(16'h8000 + 16'(i), 8'($urandom_range(0, 255)));
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // IF fetch
    run_req(1'b1, 4'd0, 32'h1000, 32'd0, -1, 0, -1, 1'b1, lat, rd);
    check32("if_lat", 32'(lat), 32'd6);
    check32("if_inst", rd, 32'h00000513);
    for (int k = 1; k <= 4; k++) check32("if_ram_a", tr_a[k], 32'h1000 + 32'(k - 1));
    @(negedge clk);
    check32("if_done_one_cycle", {31'd0, if_done}, 32'd0);
    check32("if_inst_hold", if_inst, 32'h00000513);

    // Arbitration: LB beats IF; IF follows without a bubble
    fork
      run_req(1'b0, LB, 32'h20, 32'd0, -1, 0, -1, 1'b1, lat, rd);
      run_req(1'b1, 4'd0, 32'h1000, 32'd0, -1, 0, -1, 1'b0, lat_i, rd_i);
    join
    check32("arb_lb_lat", 32'(lat), 32'd3);
    check32("arb_lb_data", rd, 32'hFFFFFF80);
    check32("arb_if_lat", 32'(lat_i), 32'd9);
    check32("arb_if_data", rd_i, 32'h00000513);
    run_req(1'b0, LBU, 32'h20, 32'd0, -1, 0, -1, 1'b1, lat, rd);
    check32("lbu_data", rd, 32'h00000080);

    // Store halfword
    run_req(1'b0, SH, 32'h3001, 32'h1234ABCD, -1, 0, -1, 1'b1, lat, rd);
    check32("sh_lat", 32'(lat), 32'd3);
    check32("sh_wr1", {31'd0, tr_wr[1]}, 32'd1);
    check32("sh_a1", tr_a[1], 32'h3001);
    check32("sh_d1", {24'd0, tr_do[1]}, 32'h000000CD);
    check32("sh_wr2", {31'd0, tr_wr[2]}, 32'd1);
    check32("sh_a2", tr_a[2], 32'h3002);
    check32("sh_d2", {24'd0, tr_do[2]}, 32'h000000AB);
    check32("sh_wr3", {31'd0, tr_wr[3]}, 32'd0);

    // Address wrap
    run_req(1'b0, LH, 32'hFFFFFFFF, 32'd0, -1, 0, -1, 1'b1, lat, rd);
    check32("wrap_a1", tr_a[1], 32'hFFFFFFFF);
    check32("wrap_a2", tr_a[2], 32'h00000000);
    check32("wrap_data", rd, 32'hFFFF9234);

    // Flush during fetch at cnt=2
    run_req(1'b1, 4'd0, 32'h1000, 32'd0, -1, 0, 3, 1'b1, lat, rd);
    check32("flush_no_done_lat", 32'(lat), 32'hFFFFFFFF);
    check32("flush_ifd_cnt", 32'(tr_ifd_cnt), 32'd0);
    check32("flush_busy_before", {31'd0, tr_busy[3]}, 32'd1);
    check32("flush_busy_after", {31'd0, tr_busy[4]}, 32'd0);
    run_req(1'b1, 4'd0, 32'h2000, 32'd0, -1, 0, -1, 1'b1, lat, rd);
    check32("post_flush_lat", 32'(lat), 32'd6);
    check32("post_flush_inst", rd, model_load(1'b1, 4'd0, 32'h2000));

    // Read stall at cnt=2 for 2 cycles
    run_req(1'b0, LW, 32'h40, 32'd0, 3, 2, -1, 1'b1, lat, rd);
    check32("stall_lw_lat", 32'(lat), 32'd10);
    check32("stall_lw_data", rd, 32'hDEADBEEF);
    check32("stall_lw_restart_a", tr_a[5], 32'h40);
    n_wr = 0;
    for (int k = 0; k <= 10; k++) if (tr_wr[k]) n_wr++;
    check32("stall_lw_no_wr", 32'(n_wr), 32'd0);

    // Write stall at cnt=1 for 2 cycles
    run_req(1'b0, SW, 32'h50, 32'h11223344, 2, 2, -1, 1'b1, lat, rd);
    check32("stall_sw_lat", 32'(lat), 32'd7);
    n_wr = 0;
    for (int k = 0; k <= 7; k++) if (tr_wr[k]) n_wr++;
    check32("stall_sw_wr_cnt", 32'(n_wr), 32'd4);
    check32("stall_sw_wr_gap", {31'd0, tr_wr[2]}, 32'd0);
    check32("stall_sw_mem", {ram_mem[16'h53], ram_mem[16'h52], ram_mem[16'h51], ram_mem[16'h50]},
            32'h11223344);

    // Randomized traffic in 0x8000..0x80FF
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind    = $urandom_range(0, 8);
      is_if_r = (kind == 8);
      op_r    = is_if_r ? 4'd0 : ops[kind];
      addr_r  = 32'h8000 + 32'($urandom_range(0, 252));
      wd_r    = $urandom;
      if (!is_if_r && (op_r == SB || op_r == SH || op_r == SW)) begin
        exp_q.push_back(32'(model_size(1'b0, op_r) + 1));
        model_store(op_r, addr_r, wd_r);
        run_req(1'b0, op_r, addr_r, wd_r, -1, 0, -1, 1'b1, lat, rd);
        check32("rnd_st_lat", 32'(lat), exp_q.pop_front());
      end else begin
        exp_q.push_back(32'(model_size(is_if_r, op_r) + 2));
        exp_q.push_back(model_load(is_if_r, op_r, addr_r));
        run_req(is_if_r, op_r, addr_r, wd_r, -1, 0, -1, 1'b1, lat, rd);
        check32("rnd_ld_lat", 32'(lat), exp_q.pop_front());
        check32("rnd_ld_data", rd, exp_q.pop_front());
      end
    end
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 256; i++)
      if (ram_mem[16'h8000 + 16'(i)] !== ref_mem[16'h8000 + 16'(i)]) errs++;
    check32("rnd_mem_image", 32'(errs), 32'd0);

    // Asynchronous reset in the middle of a word store
    @(posedge clk); #1;
    mem_req = 1'b1; mem_op = SW; mem_addr = 32'h60; mem_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check32("arst_pre_wr", {31'd0, ram_wr}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check32("arst_ram_wr", {31'd0, ram_wr}, 32'd0);
    check32("arst_busy", {31'd0, busy}, 32'd0);
    check32("arst_ram_a", ram_a, 32'd0);
    check32("arst_ram_dout", {24'd0, ram_dout}, 32'd0);
    check32("arst_mem_rdata", mem_rdata, 32'd0);
    check32("arst_if_inst", if_inst, 32'd0);
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_wr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_done) n_wr++;
    end
    check32("arst_no_done", 32'(n_wr), 32'd0);
    check32("arst_byte0", {24'd0, ram_mem[16'h60]}, 32'h000000A5);
    check32("arst_byte1", {24'd0, ram_mem[16'h61]}, 32'h0000005A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
